// File: rtl/riscv_multicycle_controller.sv
// rtl/riscv_multicycle_controller.sv - multicycle RISC-V control FSM with ALU and immediate decoders
module riscv_multicycle_controller #(
  parameter int STATE_W  = 4,
  parameter bit ERR_TRAP = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [6:0]         op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               zero,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               reg_write,
  output logic [1:0]         imm_src,
  output logic [2:0]         alu_control,
  output logic               illegal,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_ERROR    = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t     state;
  logic [1:0] alu_op;
  logic       branch;
  logic       pc_update;
  logic       ir_write_raw;
  logic       mem_write_raw;
  logic       reg_write_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      case (state)
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= S_MEMADR;
            OP_R:         state <= S_EXECR;
            OP_I:         state <= S_EXECI;
            OP_JAL:       state <= S_JAL;
            OP_BEQ:       state <= S_BEQ;
            default:      state <= ERR_TRAP ? S_ERROR : S_FETCH;
          endcase
        end
        S_MEMADR:                   state <= (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:                  state <= S_MEMWB;
        S_EXECR, S_EXECI, S_JAL:    state <= S_ALUWB;
        S_ERROR:                    state <= S_ERROR;
        default:                    state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    adr_src       = 1'b0;
    ir_write_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    result_src    = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    branch        = 1'b0;
    pc_update     = 1'b0;
    illegal       = 1'b0;
    case (state)
      S_FETCH: begin
        ir_write_raw = 1'b1;
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        pc_update    = 1'b1;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src    = 2'b01;
        reg_write_raw = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src       = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      S_ALUWB: reg_write_raw = 1'b1;
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
      end
      S_ERROR: illegal = 1'b1;
      default: ;
    endcase
  end

  // Write enables are held off for the whole time reset is asserted, even though FETCH drives them.
  assign pc_write  = rst_n & (pc_update | (branch & zero));
  assign ir_write  = rst_n & ir_write_raw;
  assign mem_write = rst_n & mem_write_raw;
  assign reg_write = rst_n & reg_write_raw;

  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b00: alu_control = 3'b000;
      2'b01: alu_control = 3'b001;
      default: begin
        case (funct3)
          // Only R-type (op[5] = 1) uses funct7b5 to pick sub; addi ignores it.
          3'b000:  alu_control = ({op[5], funct7b5} == 2'b11) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  assign state_o = STATE_W'(state);

endmodule

// File: tb/tb_riscv_multicycle_controller.sv
// tb/tb_riscv_multicycle_controller.sv - scoreboard bench for riscv_multicycle_controller
module tb_riscv_multicycle_controller;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMREAD = 4'd3,
                         S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6, S_EXECI = 4'd7,
                         S_ALUWB = 4'd8, S_JAL = 4'd9, S_BEQ = 4'd10, S_ERROR = 4'd11;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;

  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state_o;

  logic       n_pc_write, n_adr_src, n_mem_write, n_ir_write, n_reg_write, n_illegal;
  logic [1:0] n_result_src, n_alu_src_a, n_alu_src_b, n_imm_src;
  logic [2:0] n_alu_control;
  logic [3:0] n_state_o;

  riscv_multicycle_controller #(.STATE_W(4), .ERR_TRAP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write), .ir_write(ir_write),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .reg_write(reg_write), .imm_src(imm_src), .alu_control(alu_control),
    .illegal(illegal), .state_o(state_o)
  );

  riscv_multicycle_controller #(.STATE_W(4), .ERR_TRAP(1'b0)) dut_nt (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
    .pc_write(n_pc_write), .adr_src(n_adr_src), .mem_write(n_mem_write), .ir_write(n_ir_write),
    .result_src(n_result_src), .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b),
    .reg_write(n_reg_write), .imm_src(n_imm_src), .alu_control(n_alu_control),
    .illegal(n_illegal), .state_o(n_state_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] st;
    logic [3:0] nt;
    logic       pcw, adr, memw, irw, regw, ill;
    logic [1:0] res, sa, sb, imm;
    logic [2:0] alu;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc_no = 0;

  logic       pend_rstn = 1'b0;
  logic [6:0] pend_op = 7'd0;
  logic [2:0] pend_f3 = 3'd0;
  logic       pend_f7 = 1'b0;
  logic       pend_zero = 1'b0;
  logic [1:0] pend_imm = 2'b00;
  int         nt_ovr = -1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc_no, act, exp);
    end
  endtask

  task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                           input logic z, input logic [1:0] imm);
    pend_op = o; pend_f3 = f3; pend_f7 = f7; pend_zero = z; pend_imm = imm;
  endtask

  // One clock: apply pending inputs, then queue the outputs the state table calls for.
  task automatic cyc(input logic [3:0] st, input logic [2:0] alu, input logic pcw);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = pend_rstn; op = pend_op; funct3 = pend_f3; funct7b5 = pend_f7; zero = pend_zero;
    e.st = st; e.nt = (nt_ovr < 0) ? st : 4'(nt_ovr);
    e.pcw = pcw; e.alu = alu; e.imm = pend_imm;
    e.adr = 0; e.memw = 0; e.irw = 0; e.regw = 0; e.ill = 0;
    e.res = 2'b00; e.sa = 2'b00; e.sb = 2'b00;
    case (st)
      S_FETCH:    begin e.irw = pend_rstn; e.sb = 2'b10; e.res = 2'b10; end
      S_DECODE:   begin e.sa = 2'b01; e.sb = 2'b01; end
      S_MEMADR:   begin e.sa = 2'b10; e.sb = 2'b01; end
      S_MEMREAD:  e.adr = 1;
      S_MEMWB:    begin e.res = 2'b01; e.regw = 1; end
      S_MEMWRITE: begin e.adr = 1; e.memw = 1; end
      S_EXECR:    e.sa = 2'b10;
      S_EXECI:    begin e.sa = 2'b10; e.sb = 2'b01; end
      S_ALUWB:    e.regw = 1;
      S_JAL:      begin e.sa = 2'b01; e.sb = 2'b10; end
      S_BEQ:      e.sa = 2'b10;
      S_ERROR:    e.ill = 1;
      default: ;
    endcase
    sb.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cyc_no++;
        chk("state",       8'(state_o),     8'(e.st));
        chk("nt_state",    8'(n_state_o),   8'(e.nt));
        chk("pc_write",    8'(pc_write),    8'(e.pcw));
        chk("adr_src",     8'(adr_src),     8'(e.adr));
        chk("mem_write",   8'(mem_write),   8'(e.memw));
        chk("ir_write",    8'(ir_write),    8'(e.irw));
        chk("reg_write",   8'(reg_write),   8'(e.regw));
        chk("illegal",     8'(illegal),     8'(e.ill));
        chk("result_src",  8'(result_src),  8'(e.res));
        chk("alu_src_a",   8'(alu_src_a),   8'(e.sa));
        chk("alu_src_b",   8'(alu_src_b),   8'(e.sb));
        chk("imm_src",     8'(imm_src),     8'(e.imm));
        chk("alu_control", 8'(alu_control), 8'(e.alu));
      end
    end
  end

  initial begin
    int n;
    // reset held
    pend_rstn = 0;
    set_instr(7'b0000000, 3'b000, 0, 0, 2'b00);
    cyc(S_FETCH, 3'b000, 0);
    cyc(S_FETCH, 3'b000, 0);
    // lw
    pend_rstn = 1;
    set_instr(7'b0000011, 3'b010, 0, 0, 2'b00);
    cyc(S_FETCH, 3'b000, 1); cyc(S_DECODE, 3'b000, 0); cyc(S_MEMADR, 3'b000, 0);
    cyc(S_MEMREAD, 3'b000, 0); cyc(S_MEMWB, 3'b000, 0);
    // sw
    set_instr(7'b0100011, 3'b010, 0, 0, 2'b01);
    cyc(S_FETCH, 3'b000, 1); cyc(S_DECODE, 3'b000, 0); cyc(S_MEMADR, 3'b000, 0);
    cyc(S_MEMWRITE, 3'b000, 0);
    // sub, with zero high to show it does not reach pc_write outside BEQ
    set_instr(7'b0110011, 3'b000, 1, 1, 2'b00);
    cyc(S_FETCH, 3'b000, 1); cyc(S_DECODE, 3'b000, 0); cyc(S_EXECR, 3'b001, 0);
    cyc(S_ALUWB, 3'b000, 0);
    // slt
    set_instr(7'b0110011, 3'b010, 0, 0, 2'b00);
    cyc(S_FETCH, 3'b000, 1); cyc(S_DECODE, 3'b000, 0); cyc(S_EXECR, 3'b101, 0);
    cyc(S_ALUWB, 3'b000, 0);
    // and
    set_instr(7'b0110011, 3'b111, 0, 0, 2'b00);
    cyc(S_FETCH, 3'b000, 1); cyc(S_DECODE, 3'b000, 0); cyc(S_EXECR, 3'b010, 0);
    cyc(S_ALUWB, 3'b000, 0);
    // or
    set_instr(7'b0110011, 3'b110, 0, 0, 2'b00);
    cyc(S_FETCH, 3'b000, 1); cyc(S_DECODE, 3'b000, 0); cyc(S_EXECR, 3'b011, 0);
    cyc(S_ALUWB, 3'b000, 0);
    // addi with instr[30] = 1 is still add
    set_instr(7'b0010011, 3'b000, 1, 0, 2'b00);
    cyc(S_FETCH, 3'b000, 1); cyc(S_DECODE, 3'b000, 0); cyc(S_EXECI, 3'b000, 0);
    cyc(S_ALUWB, 3'b000, 0);
    // beq taken
    set_instr(7'b1100011, 3'b000, 0, 1, 2'b10);
    cyc(S_FETCH, 3'b000, 1); cyc(S_DECODE, 3'b000, 0); cyc(S_BEQ, 3'b001, 1);
    // beq not taken
    set_instr(7'b1100011, 3'b000, 0, 0, 2'b10);
    cyc(S_FETCH, 3'b000, 1); cyc(S_DECODE, 3'b000, 0); cyc(S_BEQ, 3'b001, 0);
    // jal
    set_instr(7'b1101111, 3'b000, 0, 0, 2'b11);
    cyc(S_FETCH, 3'b000, 1); cyc(S_DECODE, 3'b000, 0); cyc(S_JAL, 3'b000, 1);
    cyc(S_ALUWB, 3'b000, 0);
    // lw aborted by reset in what would be MEMREAD, then an add
    set_instr(7'b0000011, 3'b010, 0, 0, 2'b00);
    cyc(S_FETCH, 3'b000, 1); cyc(S_DECODE, 3'b000, 0); cyc(S_MEMADR, 3'b000, 0);
    pend_rstn = 0;
    cyc(S_FETCH, 3'b000, 0); cyc(S_FETCH, 3'b000, 0);
    pend_rstn = 1;
    set_instr(7'b0110011, 3'b000, 0, 0, 2'b00);
    cyc(S_FETCH, 3'b000, 1); cyc(S_DECODE, 3'b000, 0); cyc(S_EXECR, 3'b000, 0);
    cyc(S_ALUWB, 3'b000, 0);
    // illegal op: trap instance sticks in ERROR, non-trap instance keeps fetching
    set_instr(7'b1111111, 3'b000, 0, 0, 2'b00);
    cyc(S_FETCH, 3'b000, 1); cyc(S_DECODE, 3'b000, 0);
    nt_ovr = S_FETCH;  cyc(S_ERROR, 3'b000, 0);
    nt_ovr = S_DECODE; cyc(S_ERROR, 3'b000, 0);
    nt_ovr = S_FETCH;  cyc(S_ERROR, 3'b000, 0);
    nt_ovr = -1;
    pend_rstn = 0;
    set_instr(7'b0000011, 3'b010, 0, 0, 2'b00);
    cyc(S_FETCH, 3'b000, 0);
    pend_rstn = 1;
    cyc(S_FETCH, 3'b000, 1); cyc(S_DECODE, 3'b000, 0);

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
